// File: rtl/sint_cmp_pkg.sv
// Shared types and helpers for the signed/unsigned stream comparator.
// op_t predicate codes, legality check, and a width-generic greater-than.
package sint_cmp_pkg;

  localparam int unsigned EXT_W = 64;

  typedef enum logic [2:0] {
    OP_EQ = 3'd0,
    OP_NE = 3'd1,
    OP_LT = 3'd2,
    OP_LE = 3'd3,
    OP_GT = 3'd4,
    OP_GE = 3'd5
  } op_t;

  function automatic logic op_is_legal(
    input logic [2:0] op
  );
    return op <= 3'd5;
  endfunction

  // v holds a w-bit value zero-extended to EXT_W bits.
  function automatic logic [EXT_W-1:0] sext(
    input logic [EXT_W-1:0] v,
    input int unsigned      w,
    input logic             sgn
  );
    logic [EXT_W-1:0] t;
    logic [EXT_W-1:0] m;
    t = v >> (w - 1);
    m = ~((EXT_W'(1) << w) - EXT_W'(1));
    return (sgn & t[0]) ? (v | m) : v;
  endfunction

  function automatic logic cmp_gt(
    input logic [EXT_W-1:0] a,
    input logic [EXT_W-1:0] b,
    input int unsigned      w,
    input logic             sgn
  );
    logic [EXT_W-1:0] sa;
    logic [EXT_W-1:0] sb;
    sa = sext(a, w, sgn);
    sb = sext(b, w, sgn);
    return sgn ? ($signed(sa) > $signed(sb)) : (a > b);
  endfunction

endpackage

// File: rtl/sint_cmp_core.sv
// Combinational predicate evaluator: result = a op b, illegal for op 6/7.
// Ports: a, b, op, is_signed in; result, illegal out.
module sint_cmp_core
  import sint_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             is_signed,
  output logic             result,
  output logic             illegal
);

  logic eq;
  logic a_gt;
  logic b_gt;

  assign eq   = (a == b);
  assign a_gt = cmp_gt(EXT_W'(a), EXT_W'(b), WIDTH, is_signed);
  assign b_gt = cmp_gt(EXT_W'(b), EXT_W'(a), WIDTH, is_signed);

  always_comb begin
    result  = 1'b0;
    illegal = !op_is_legal(op);
    unique case (1'b1)
      (op == OP_EQ): result = eq;
      (op == OP_NE): result = !eq;
      (op == OP_LT): result = b_gt;
      (op == OP_LE): result = !a_gt;
      (op == OP_GT): result = a_gt;
      (op == OP_GE): result = !b_gt;
      default:       result = 1'b0;
    endcase
  end

endmodule

// File: rtl/sint_cmp_stream.sv
// Registered valid/ready comparator stage with running max and true count.
// Ports: CLK, ASYNCRESETN, I0/I1/op/is_signed/I_valid/I_ready, O/O_valid/O_ready, clear, stats.
module sint_cmp_stream
  import sint_cmp_pkg::*;
#(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [WIDTH-1:0]     I0,
  input  logic [WIDTH-1:0]     I1,
  input  logic [2:0]           op,
  input  logic                 is_signed,
  input  logic                 I_valid,
  output logic                 I_ready,
  output logic                 O,
  output logic                 O_valid,
  input  logic                 O_ready,
  input  logic                 clear,
  output logic [WIDTH-1:0]     max_O,
  output logic                 max_valid,
  output logic [CNT_WIDTH-1:0] true_cnt,
  output logic                 err
);

  logic accept;
  logic res;
  logic ill;
  logic keep_max;
  logic new_max;

  assign I_ready = !O_valid || O_ready;
  assign accept  = I_valid && I_ready;

  sint_cmp_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a        (I0),
    .b        (I1),
    .op       (op),
    .is_signed(is_signed),
    .result   (res),
    .illegal  (ill)
  );

  // A same-cycle clear discards the old max, so the beat seeds it.
  assign keep_max = max_valid && !clear;
  assign new_max  = !keep_max
                 || cmp_gt(EXT_W'(I0), EXT_W'(max_O), WIDTH, is_signed);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      O       <= 1'b0;
      O_valid <= 1'b0;
    end else if (accept) begin
      O       <= res;
      O_valid <= 1'b1;
    end else if (O_ready) begin
      O_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      max_O     <= '0;
      max_valid <= 1'b0;
    end else if (accept) begin
      max_valid <= 1'b1;
      if (new_max) max_O <= I0;
    end else if (clear) begin
      max_O     <= '0;
      max_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      true_cnt <= '0;
      err      <= 1'b0;
    end else if (clear) begin
      true_cnt <= (accept && res) ? CNT_WIDTH'(1) : '0;
      err      <= accept && ill;
    end else if (accept) begin
      if (res && !(&true_cnt)) true_cnt <= true_cnt + 1'b1;
      if (ill) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sint_cmp_stream.sv
// Randomized and directed bench for sint_cmp_stream against an integer model.
// Runs WIDTH=7, CNT_WIDTH=2 so counter saturation is reached quickly.
module tb_sint_cmp_stream;

  localparam int W  = 7;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          ASYNCRESETN;
  logic [W-1:0]  I0, I1;
  logic [2:0]    op;
  logic          is_signed;
  logic          I_valid;
  logic          I_ready;
  logic          O;
  logic          O_valid;
  logic          O_ready;
  logic          clear;
  logic [W-1:0]  max_O;
  logic          max_valid;
  logic [CW-1:0] true_cnt;
  logic          err;

  int n_vec = 0;
  int n_bad = 0;

  bit           m_o, m_ov, m_mv, m_err;
  logic [W-1:0] m_max;
  int           m_cnt;

  sint_cmp_stream #(
    .WIDTH(W),
    .CNT_WIDTH(CW)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .I0         (I0),
    .I1         (I1),
    .op         (op),
    .is_signed  (is_signed),
    .I_valid    (I_valid),
    .I_ready    (I_ready),
    .O          (O),
    .O_valid    (O_valid),
    .O_ready    (O_ready),
    .clear      (clear),
    .max_O      (max_O),
    .max_valid  (max_valid),
    .true_cnt   (true_cnt),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int to_int(logic [W-1:0] x, bit s);
    if (s && x[W-1]) return int'(x) - (1 << W);
    return int'(x);
  endfunction

  function automatic bit pred(
    logic [W-1:0] a, logic [W-1:0] b, logic [2:0] o, bit s
  );
    int x = to_int(a, s);
    int y = to_int(b, s);
    case (o)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd2: return x < y;
      3'd3: return x <= y;
      3'd4: return x > y;
      3'd5: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_o = 0; m_ov = 0; m_mv = 0; m_err = 0;
    m_max = '0; m_cnt = 0;
  endtask

  task automatic chk_all(input string p);
    chk({p, "_O"}, O, m_o);
    chk({p, "_O_valid"}, O_valid, m_ov);
    chk({p, "_max_O"}, max_O, m_max);
    chk({p, "_max_valid"}, max_valid, m_mv);
    chk({p, "_true_cnt"}, true_cnt, m_cnt);
    chk({p, "_err"}, err, m_err);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   o,
    input  bit           s,
    input  bit           v,
    input  bit           r,
    input  bit           c,
    output bit           acc
  );
    bit p;
    bit ill;
    I0 = a; I1 = b; op = o; is_signed = s;
    I_valid = v; O_ready = r; clear = c;
    #1;
    chk("I_ready", I_ready, !m_ov || r);
    acc = v && (!m_ov || r);
    p   = pred(a, b, o, s);
    ill = (o > 3'd5);
    @(posedge CLK);
    if (acc) begin
      m_o = p; m_ov = 1;
    end else if (m_ov && r) begin
      m_ov = 0;
    end
    if (c) begin
      m_mv = 0; m_max = '0; m_cnt = 0; m_err = 0;
    end
    if (acc) begin
      if (!m_mv || to_int(a, s) > to_int(m_max, s)) m_max = a;
      m_mv = 1;
      if (p && m_cnt < CNT_MAX) m_cnt++;
      if (ill) m_err = 1;
    end
    #1;
    chk_all("step");
    @(negedge CLK);
  endtask

  task automatic do_reset();
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    model_reset();
    chk_all("rst");
    chk("rst_I_ready", I_ready, 1'b1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   o;
    bit           s;
  } beat_t;

  initial begin
    bit    acc;
    beat_t q[$];
    int    cyc;

    ASYNCRESETN = 1'b0;
    I0 = '0; I1 = '0; op = '0; is_signed = 0;
    I_valid = 0; O_ready = 0; clear = 0;
    model_reset();
    #3;
    chk_all("init");
    chk("init_I_ready", I_ready, 1'b1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    // Signed vs unsigned ordering of 7'h40 vs 7'h3F under gt.
    step(7'h40, 7'h3F, 3'd4, 1, 1, 1, 0, acc);
    chk("gt_signed", O, 1'b0);
    step(7'h40, 7'h3F, 3'd4, 0, 1, 1, 0, acc);
    chk("gt_unsigned", O, 1'b1);
    step('0, '0, 3'd0, 0, 0, 1, 0, acc);

    // Backpressure: ready only on the first cycle, then released.
    q.push_back('{7'h40, 7'h3F, 3'd4, 1'b0});
    q.push_back('{7'h40, 7'h3F, 3'd4, 1'b1});
    q.push_back('{7'h05, 7'h05, 3'd0, 1'b0});
    q.push_back('{7'h05, 7'h05, 3'd1, 1'b0});
    cyc = 0;
    while ((q.size() > 0 || m_ov) && cyc < 20) begin
      bit r = (cyc == 0) || (cyc >= 4);
      if (q.size() > 0)
        step(q[0].a, q[0].b, q[0].o, q[0].s, 1, r, 0, acc);
      else
        step('0, '0, 3'd0, 0, 0, r, 0, acc);
      if (acc) void'(q.pop_front());
      if (cyc == 2) begin
        chk("bp_O_valid", O_valid, 1'b1);
        chk("bp_O_held", O, 1'b1);
      end
      cyc++;
    end
    chk("bp_drained", q.size(), 0);

    // Statistics with signed ge against zero.
    step('0, '0, 3'd0, 0, 0, 1, 1, acc);
    step(7'h7B, 7'h00, 3'd5, 1, 1, 1, 0, acc);
    step(7'h03, 7'h00, 3'd5, 1, 1, 1, 0, acc);
    step(7'h40, 7'h00, 3'd5, 1, 1, 1, 0, acc);
    step(7'h02, 7'h00, 3'd5, 1, 1, 1, 0, acc);
    chk("stat_max", max_O, 7'd3);
    chk("stat_max_valid", max_valid, 1'b1);
    chk("stat_cnt", true_cnt, 2);

    // Saturation, then an illegal op.
    step('0, '0, 3'd0, 0, 0, 1, 1, acc);
    for (int i = 0; i < 5; i++)
      step(7'(i), 7'(i), 3'd0, 0, 1, 1, 0, acc);
    chk("sat_cnt", true_cnt, 3);
    step(7'h01, 7'h01, 3'd7, 0, 1, 1, 0, acc);
    chk("ill_O", O, 1'b0);
    chk("ill_err", err, 1'b1);
    chk("ill_cnt", true_cnt, 3);

    // Clear coinciding with an accepted beat.
    step(7'd9, 7'd9, 3'd0, 0, 1, 1, 1, acc);
    chk("clracc_max", max_O, 7'd9);
    chk("clracc_cnt", true_cnt, 1);
    chk("clracc_err", err, 1'b0);

    // Async reset while a result is pending, then 1-cycle latency.
    step(7'h10, 7'h20, 3'd2, 0, 1, 0, 0, acc);
    chk("pre_rst_O_valid", O_valid, 1'b1);
    do_reset();
    step(7'h10, 7'h20, 3'd2, 0, 1, 1, 0, acc);
    chk("post_rst_O_valid", O_valid, 1'b1);
    chk("post_rst_O", O, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] a, b;
      logic [2:0]   o;
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? a : W'($urandom);
      o = ($urandom_range(0, 15) < 14) ? 3'($urandom_range(0, 5))
                                        : 3'($urandom_range(6, 7));
      step(a, b, o, 1'($urandom),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0, acc);
      if (i % 700 == 699) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
